// File: rtl/seq_divider.sv
// Sequential 8-by-4 unsigned restoring divider, one quotient bit per clock, MSB first.
// Define DIV_ZERO_FAST_EN to resolve a zero divisor at accept and skip the RUN phase.
module seq_divider (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       div_zero
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e     state_q, state_d;
  logic [7:0] dvd_q;
  logic [7:0] quo_q;
  logic [3:0] dvs_q;
  logic [3:0] rem_q;
  logic [2:0] cnt_q;
  logic       dz_q;

  logic       accept;
  logic [4:0] trial;
  logic       fit;
  logic [3:0] diff;

  assign accept = (state_q == StIdle) && start;

  // rem_q < dvs_q holds between steps, so the difference always fits in 4 bits.
  always_comb begin
    trial = {rem_q, dvd_q[7]};
    fit   = trial >= {1'b0, dvs_q};
    diff  = trial[3:0] - dvs_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
`ifdef DIV_ZERO_FAST_EN
          state_d = (divisor == 4'd0) ? StDone : StRun;
`else
          state_d = StRun;
`endif
        end
      end
      StRun:   if (cnt_q == 3'd7) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q <= 8'h00;
      dvs_q <= 4'h0;
      quo_q <= 8'h00;
      rem_q <= 4'h0;
      cnt_q <= 3'd0;
      dz_q  <= 1'b0;
    end else if (accept) begin
      dvd_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= 3'd0;
      dz_q  <= (divisor == 4'd0);
`ifdef DIV_ZERO_FAST_EN
      if (divisor == 4'd0) begin
        quo_q <= 8'hFF;
        rem_q <= dividend[3:0];
      end else begin
        quo_q <= 8'h00;
        rem_q <= 4'h0;
      end
`else
      quo_q <= 8'h00;
      rem_q <= 4'h0;
`endif
    end else if (state_q == StRun) begin
      dvd_q <= {dvd_q[6:0], 1'b0};
      rem_q <= fit ? diff : trial[3:0];
      quo_q <= {quo_q[6:0], fit};
      cnt_q <= cnt_q + 3'd1;
    end
  end

  always_comb begin
    busy      = (state_q == StRun);
    done      = (state_q == StDone);
    quotient  = quo_q;
    remainder = rem_q;
    div_zero  = dz_q;
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, a monitor pops on done.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_zero;

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  logic prev_done = 1'b0;

`ifdef DIV_ZERO_FAST_EN
  localparam bit Fast = 1'b1;
`else
  localparam bit Fast = 1'b0;
`endif

  seq_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [3:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 4'd0) begin
      e.q  = 8'hFF;
      e.r  = a[3:0];
      e.dz = 1'b1;
    end else begin
      e.q  = a / {4'd0, b};
      e.r  = 4'(a % {4'd0, b});
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every done pulse consumes one expected result.
  always @(posedge clk) begin
    #1;
    if (done) begin
      done_cnt++;
      chk("done_pulse_width", {31'd0, prev_done}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("quotient %0d/%0d", e.a, e.b), {24'd0, quotient}, {24'd0, e.q});
        chk($sformatf("remainder %0d/%0d", e.a, e.b), {28'd0, remainder}, {28'd0, e.r});
        chk($sformatf("div_zero %0d/%0d", e.a, e.b), {31'd0, div_zero}, {31'd0, e.dz});
        if (e.b != 4'd0)
          chk($sformatf("identity %0d/%0d", e.a, e.b),
              32'(quotient) * 32'(e.b) + 32'(remainder), 32'(e.a));
      end
    end
    prev_done = done;
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy || done) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // Called at #1 after the accept edge; counts further edges until done is seen.
  task automatic wait_done(input int exp_edges, input string name);
    int edges = 0;
    while (!done && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk(name, edges, exp_edges);
  endtask

  task automatic do_div(input logic [7:0] a, input logic [3:0] b);
    bit fz;
    fz = Fast && (b == 4'd0);
    wait_idle();
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(model(a, b));
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, fz ? 32'd0 : 32'd1);
    wait_done(fz ? 0 : 8, "done_latency");
  endtask

  initial begin
    int d0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 8'h00;
    divisor  = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quotient", {24'd0, quotient}, 32'd0);
    chk("rst_remainder", {28'd0, remainder}, 32'd0);
    chk("rst_div_zero", {31'd0, div_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_div(8'd200, 4'd13);
    do_div(8'd255, 4'd1);
    do_div(8'd7, 4'd9);
    do_div(8'd225, 4'd15);
    do_div(8'hA7, 4'd0);

    // Start pulsed during RUN must be ignored.
    d0 = done_cnt;
    wait_idle();
    dividend = 8'd100;
    divisor  = 4'd7;
    start    = 1'b1;
    sb.push_back(model(8'd100, 4'd7));
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    dividend = 8'd50;
    divisor  = 4'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(4, "done_latency_ignored_start");
    repeat (12) @(posedge clk);
    #1;
    chk("single_done_ignored_start", done_cnt - d0, 32'd1);

    // Start held high: second op accepted on the first IDLE cycle after DONE.
    wait_idle();
    dividend = 8'd225;
    divisor  = 4'd15;
    start    = 1'b1;
    sb.push_back(model(8'd225, 4'd15));
    @(posedge clk);
    #1;
    dividend = 8'd255;
    divisor  = 4'd1;
    sb.push_back(model(8'd255, 4'd1));
    wait_done(8, "b2b_first_latency");
    @(posedge clk);
    #1;
    chk("b2b_idle_busy", {31'd0, busy}, 32'd0);
    chk("b2b_idle_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_second_accept", {31'd0, busy}, 32'd1);
    wait_done(8, "b2b_second_latency");

    // Reset in the middle of RUN aborts without a done pulse.
    do_div(8'hA7, 4'd0);
    wait_idle();
    d0 = done_cnt;
    dividend = 8'd200;
    divisor  = 4'd13;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_remainder", {28'd0, remainder}, 32'd12);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_busy", {31'd0, busy}, 32'd0);
    chk("midrun_rst_quotient", {24'd0, quotient}, 32'd0);
    chk("midrun_rst_remainder", {28'd0, remainder}, 32'd0);
    chk("midrun_rst_div_zero", {31'd0, div_zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("no_done_after_abort", done_cnt - d0, 32'd0);
    do_div(8'd60, 4'd4);

    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_div(8'(a), 4'(b));
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
